// File: rtl/mux_sel_reg.sv
// mux_sel_reg: registered N-channel selector with a one-entry valid/ready output stage.
//
// Picks one WIDTH-bit channel from a flattened input bus, either by an explicit
// select request (direct mode) or by cycling through every channel (scan mode).
// Selects at or above NCH are flagged with out_err and return zero data.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   mode       0 = direct (sel-driven), 1 = scan (auto-increment)
//   sel        requested channel (direct mode only)
//   sel_valid  sel is a request
//   sel_ready  request accepted when sel_valid && sel_ready
//   out_data   selected channel value, registered
//   out_ch     channel index that produced out_data
//   out_err    out_data came from an out-of-range select
//   out_valid  output holds an unconsumed result
//   out_ready  consumer takes the result when out_valid && out_ready

module mux_sel_reg #(
  parameter int unsigned NCH   = 32,
  parameter int unsigned WIDTH = 2,
  parameter int unsigned SELW  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  scan_ptr_q, scan_ptr_d;
  logic             mode_prev_q, mode_prev_d;

  logic             slot_free;
  logic             scan_restart;
  logic [SELW-1:0]  scan_ch;
  logic             scan_last;
  logic             sel_oor;
  logic [SELW-1:0]  pick_ch;
  logic [WIDTH-1:0] pick_data;

  assign slot_free = !out_valid_q || out_ready;

  // A 0 -> 1 mode edge (seen only when the slot can take a load) restarts the scan at channel 0.
  assign scan_restart = mode && !mode_prev_q;
  assign scan_ch      = scan_restart ? '0 : scan_ptr_q;
  assign scan_last    = (32'(scan_ch) == NCH - 1);
  assign sel_oor      = (32'(sel) >= NCH);
  assign pick_ch      = mode ? scan_ch : sel;

  // Channel mux; an out-of-range index matches no channel and yields zero.
  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pick_ch == SELW'(i)) begin
        pick_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_ready = slot_free && !mode;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    scan_ptr_d  = scan_ptr_q;
    mode_prev_d = mode_prev_q;

    // A stalled result freezes everything, including mode tracking and the scan pointer.
    if (slot_free) begin
      mode_prev_d = mode;
      if (mode) begin
        out_data_d  = pick_data;
        out_ch_d    = scan_ch;
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
        scan_ptr_d  = scan_last ? '0 : scan_ch + SELW'(1);
      end else if (sel_valid) begin
        out_data_d  = sel_oor ? '0 : pick_data;
        out_ch_d    = sel;
        out_err_d   = sel_oor;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      scan_ptr_q  <= '0;
      mode_prev_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      scan_ptr_q  <= scan_ptr_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_sel_reg.sv
// Testbench for mux_sel_reg (NCH = 31 so that sel = 31 is out of range with SELW = 5).
// A negedge monitor keeps a reference model: it pushes the expected result when a load is
// due at the next edge and compares the held output against the queue head while valid.

module tb_mux_sel_reg;

  localparam int NCH   = 31;
  localparam int WIDTH = 2;
  localparam int SELW  = 5;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  ch;
    logic             err;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic                 sel_valid;
  logic                 sel_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_err;
  logic                 out_valid;
  logic                 out_ready;

  int unsigned total;
  int unsigned bad;

  exp_t            exp_q[$];
  logic            m_valid;
  logic [SELW-1:0] m_ptr;
  logic            m_prev;

  mux_sel_reg #(
    .NCH   (NCH),
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .mode      (mode),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic            free;
    logic [SELW-1:0] ch;
    exp_t            e;
    if (!rst_n) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_ptr   = '0;
      m_prev  = 1'b0;
    end else begin
      free = !m_valid || out_ready;
      check_eq("out_valid", 32'(out_valid), 32'(m_valid));
      check_eq("sel_ready", 32'(sel_ready), 32'(free && !mode));
      if (m_valid) begin
        check_eq("q_size", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check_eq("out_data", 32'(out_data), 32'(e.data));
          check_eq("out_ch", 32'(out_ch), 32'(e.ch));
          check_eq("out_err", 32'(out_err), 32'(e.err));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (free) begin
        if (mode) begin
          ch = m_prev ? m_ptr : '0;
          e.data = in_data[int'(ch)*WIDTH +: WIDTH];
          e.ch   = ch;
          e.err  = 1'b0;
          exp_q.push_back(e);
          m_valid = 1'b1;
          m_ptr   = (int'(ch) == NCH - 1) ? '0 : ch + 5'd1;
        end else if (sel_valid) begin
          e.ch  = sel;
          e.err = (int'(sel) >= NCH);
          e.data = e.err ? '0 : in_data[int'(sel)*WIDTH +: WIDTH];
          exp_q.push_back(e);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
        m_prev = mode;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_mod4();
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = 2'(i % 4);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    sel_valid = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    set_mod4();
    repeat (3) step();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // Direct sweep of every in-range channel, then the out-of-range and top valid select.
    for (int i = 0; i < NCH; i++) begin
      sel = 5'(i);
      sel_valid = 1'b1;
      step();
    end
    sel = 5'd31;
    step();
    check_eq("oor_err", 32'(out_err), 32'd1);
    check_eq("oor_data", 32'(out_data), 32'd0);
    sel = 5'd30;
    step();
    check_eq("top_err", 32'(out_err), 32'd0);
    check_eq("top_data", 32'(out_data), 32'(30 % 4));
    sel_valid = 1'b0;
    step();

    // Backpressure: held result must ignore later in_data changes.
    in_data[5*WIDTH +: WIDTH] = 2'b01;
    sel = 5'd5;
    sel_valid = 1'b1;
    step();
    out_ready = 1'b0;
    sel = 5'd7;
    in_data[5*WIDTH +: WIDTH] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("bp_hold", 32'(out_data), 32'b01);
      check_eq("bp_ready", 32'(sel_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check_eq("bp_next", 32'(out_ch), 32'd7);
    sel_valid = 1'b0;

    // Random direct traffic.
    for (int i = 0; i < 40; i++) begin
      in_data   = 62'({$urandom(), $urandom()});
      sel       = 5'($urandom_range(0, 31));
      sel_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end

    // Scan across the wrap, then a 3-cycle stall.
    set_mod4();
    sel_valid = 1'b0;
    out_ready = 1'b1;
    mode = 1'b1;
    step();
    check_eq("scan_first", 32'(out_ch), 32'd0);
    repeat (34) step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (5) step();

    // Mode switch: two direct results, then scan restarts at channel 0.
    mode = 1'b0;
    sel = 5'd3;
    sel_valid = 1'b1;
    repeat (2) step();
    check_eq("dir_mid", 32'(out_ch), 32'd3);
    sel_valid = 1'b0;
    mode = 1'b1;
    step();
    check_eq("rescan_ch0", 32'(out_ch), 32'd0);
    repeat (3) step();

    // Reset while a result is held.
    out_ready = 1'b0;
    repeat (2) step();
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_data", 32'(out_data), 32'd0);
    check_eq("arst_ch", 32'(out_ch), 32'd0);
    check_eq("arst_err", 32'(out_err), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check_eq("post_rst_ch", 32'(out_ch), 32'd0);
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);

    // Random mixed traffic including mode toggles under stall.
    for (int i = 0; i < 60; i++) begin
      in_data   = 62'({$urandom(), $urandom()});
      mode      = 1'($urandom_range(0, 3) == 0);
      sel       = 5'($urandom_range(0, 31));
      sel_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end

    mode = 1'b0;
    sel_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_reg.md
# mux_sel_reg

Parametrised, registered N-channel selector with a valid/ready output stage and an autonomous scan mode. Picks one WIDTH-bit channel from a flattened input bus, either by an explicit select request or by cycling through all channels. Out-of-range selects are flagged rather than silently zeroed. Sits between a bank of per-channel status/data sources and a single downstream consumer that may apply backpressure.

## Interface

- NCH, 32, number of input channels (2..256)
- WIDTH, 2, bits per channel
- SELW, 5, select width; SELW >= ceil(log2(NCH)); values >= NCH are out of range
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- mode  input  1  0 = direct (sel-driven), 1 = scan (auto-increment)
- sel  input  SELW  requested channel, direct mode only
- sel_valid  input  1  sel is a request
- sel_ready  output  1  request accepted when sel_valid && sel_ready
- out_data  output  WIDTH  selected channel value, registered
- out_ch  output  SELW  channel index that produced out_data
- out_err  output  1  out_data came from an out-of-range select
- out_valid  output  1  output holds an unconsumed result
- out_ready  input  1  consumer takes result when out_valid && out_ready

## Operation

- One-entry output register; slot_free = !out_valid || out_ready.
- Direct mode (mode = 0):
  - sel_ready = slot_free.
  - On accept: out_data <= in_data[sel*WIDTH +: WIDTH], out_ch <= sel, out_err <= 0, out_valid <= 1.
  - If sel >= NCH: out_data <= 0, out_ch <= sel, out_err <= 1, out_valid <= 1.
  - slot_free and no accept: out_valid <= 0.
- Scan mode (mode = 1):
  - sel_ready = 0; sel and sel_valid ignored.
  - Internal scan_ptr (SELW bits). Whenever slot_free: load channel scan_ptr as in direct mode (out_err always 0), out_valid <= 1, scan_ptr <= (scan_ptr == NCH-1) ? 0 : scan_ptr + 1.
  - scan_ptr never holds a value >= NCH.
- Mode changes take effect only in a cycle where slot_free; while out_valid && !out_ready the held result and scan_ptr are untouched regardless of mode.
- Transition 0 -> 1 (sampled mode differs from previous cycle's sampled mode): scan_ptr restarts at 0; first scanned channel is 0.
- Transition 1 -> 0: scan_ptr retains value but is unused; any held scan result must still be consumed normally.
- in_data sampled only on the load edge; later in_data changes never alter a held result.

## Timing

- Reset (rst_n low, asynchronous): out_data = 0, out_ch = 0, out_err = 0, out_valid = 0, scan_ptr = 0, previous-mode register = 0. Deassertion synchronous to clk.
- sel_ready is combinational from out_valid and out_ready.
- Latency: accept/scan load at edge N -> out_valid, out_data visible after edge N.
- Throughput: one result per cycle when out_ready held high; no bubble.
- Backpressure: out_valid && !out_ready -> out_data, out_ch, out_err, out_valid stable; sel_ready = 0.
- Simultaneous consume and new accept in one cycle: new result replaces old, out_valid stays 1.
- Scan wrap: after channel NCH-1 next loaded channel is 0 with no gap cycle.
- Reset mid-operation: held result discarded, scan restarts at channel 0.

## Test plan

- Reset: assert rst_n = 0 mid-stream with out_valid = 1 -> all outputs 0 immediately, out_valid = 0; after release, first scan load is channel 0.
- Direct sweep, NCH = 32, WIDTH = 2, channel i = i % 4, out_ready = 1, sel = 0..31 back-to-back -> out_data = i % 4, out_ch = i one cycle later, out_err = 0, 32 results in 32 cycles.
- Out of range, NCH = 31, SELW = 5: sel = 31 and sel = 30 -> sel 31 gives out_data = 0, out_err = 1; sel 30 gives in_data channel 30, out_err = 0.
- Backpressure: sel = 5 accepted, out_ready = 0 for 4 cycles while in_data ch5 changes 2'b01 -> 2'b10 -> out_data holds 2'b01, sel_ready = 0; out_ready = 1 -> consumed, next sel accepted that same cycle.
- Scan wrap, NCH = 4, mode = 1, out_ready = 1 -> out_ch sequence 0,1,2,3,0,1 with no gaps; drop out_ready for 3 cycles at ch2 -> ch2 held, resumes with 3.
- Mode switch: scan reaches ch2, mode -> 0 for 2 cycles, then -> 1 -> direct results in between, next scan result is ch0.
